// File: rtl/ghost_mode_scheduler.sv
// Global scatter/chase/frightened sequencer for all ghosts; outputs registered, one-cycle latency.
// No backpressure: pause or tick=0 freeze both counters, but a pellet edge is still taken.
module ghost_mode_scheduler #(
    parameter int SCATTER_LONG = 420,
    parameter int SCATTER_SHORT = 300,
    parameter int CHASE_TICKS = 1200,
    parameter int FRIGHT_TICKS = 360,
    parameter int FLASH_TICKS = 120,
    parameter int CNT_W = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       pause,
    input  logic       power_pellet,
    output logic [1:0] mode,
    output logic       reverse,
    output logic       flash,
    output logic [2:0] phase,
    output logic       running
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FRIGHT = 2'd2
    } state_t;

    localparam logic [1:0] MODE_SCATTER = 2'b00;
    localparam logic [1:0] MODE_CHASE   = 2'b01;
    localparam logic [1:0] MODE_FRIGHT  = 2'b11;

    localparam logic [CNT_W-1:0] LOAD_SL     = CNT_W'(SCATTER_LONG - 1);
    localparam logic [CNT_W-1:0] LOAD_SS     = CNT_W'(SCATTER_SHORT - 1);
    localparam logic [CNT_W-1:0] LOAD_CH     = CNT_W'(CHASE_TICKS - 1);
    localparam logic [CNT_W-1:0] LOAD_FR     = CNT_W'(FRIGHT_TICKS - 1);
    localparam logic [CNT_W-1:0] FLASH_LIMIT = CNT_W'(FLASH_TICKS);
    localparam logic [2:0]       LAST_PHASE  = 3'd7;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] phase_cnt, phase_cnt_nxt;
    logic [CNT_W-1:0] fright_cnt, fright_cnt_nxt;
    logic             pellet_d;
    logic [1:0]       mode_nxt;
    logic             reverse_nxt;
    logic             flash_nxt;
    logic [2:0]       phase_nxt;
    logic             running_nxt;

    logic             active;
    logic             pellet_edge;
    logic             phase_timed;
    logic [2:0]       phase_inc;

    function automatic logic [CNT_W-1:0] phase_load(input logic [2:0] p);
        logic [CNT_W-1:0] v;
        case (p)
            3'd0, 3'd2: v = LOAD_SL;
            3'd4, 3'd6: v = LOAD_SS;
            default:    v = LOAD_CH;
        endcase
        return v;
    endfunction

    function automatic logic [1:0] phase_mode(input logic [2:0] p);
        return p[0] ? MODE_CHASE : MODE_SCATTER;
    endfunction

    assign active      = tick & ~pause & running;
    assign pellet_edge = power_pellet & ~pellet_d;
    // Phase 7 is open-ended chase: its counter never runs.
    assign phase_timed = (phase != LAST_PHASE);
    assign phase_inc   = phase + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            phase_cnt  <= LOAD_SL;
            fright_cnt <= '0;
            pellet_d   <= 1'b0;
            mode       <= MODE_SCATTER;
            reverse    <= 1'b0;
            flash      <= 1'b0;
            phase      <= 3'd0;
            running    <= 1'b0;
        end else begin
            state      <= state_nxt;
            phase_cnt  <= phase_cnt_nxt;
            fright_cnt <= fright_cnt_nxt;
            pellet_d   <= power_pellet;
            mode       <= mode_nxt;
            reverse    <= reverse_nxt;
            flash      <= flash_nxt;
            phase      <= phase_nxt;
            running    <= running_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        phase_cnt_nxt  = phase_cnt;
        fright_cnt_nxt = fright_cnt;
        mode_nxt       = mode;
        reverse_nxt    = 1'b0;
        flash_nxt      = 1'b0;
        phase_nxt      = phase;
        running_nxt    = running;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = RUN;
                    running_nxt = 1'b1;
                    mode_nxt    = MODE_SCATTER;
                end
            end

            RUN: begin
                if (active && phase_timed) begin
                    if (phase_cnt == '0) begin
                        phase_nxt     = phase_inc;
                        phase_cnt_nxt = phase_load(phase_inc);
                        mode_nxt      = phase_mode(phase_inc);
                        reverse_nxt   = 1'b1;
                    end else begin
                        phase_cnt_nxt = phase_cnt - 1'b1;
                    end
                end
                // The phase advance above stays committed; fright just overlays it.
                if (pellet_edge) begin
                    state_nxt      = FRIGHT;
                    fright_cnt_nxt = LOAD_FR;
                    mode_nxt       = MODE_FRIGHT;
                    reverse_nxt    = 1'b1;
                    flash_nxt      = (LOAD_FR < FLASH_LIMIT);
                end
            end

            FRIGHT: begin
                mode_nxt = MODE_FRIGHT;
                if (pellet_edge) begin
                    fright_cnt_nxt = LOAD_FR;
                    flash_nxt      = (LOAD_FR < FLASH_LIMIT);
                end else if (active && fright_cnt == '0) begin
                    state_nxt = RUN;
                    mode_nxt  = phase_mode(phase);
                end else begin
                    if (active) begin
                        fright_cnt_nxt = fright_cnt - 1'b1;
                    end
                    flash_nxt = (fright_cnt_nxt < FLASH_LIMIT);
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Scoreboarded bench for ghost_mode_scheduler: directed schedule scenarios plus random traffic.
module tb_ghost_mode_scheduler;

    localparam int SL = 420;
    localparam int SS = 300;
    localparam int CH = 1200;
    localparam int FR = 360;
    localparam int FL = 120;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       power_pellet = 1'b0;
    logic [1:0] mode;
    logic       reverse;
    logic       flash;
    logic [2:0] phase;
    logic       running;

    always #5 clk = ~clk;

    ghost_mode_scheduler #(
        .SCATTER_LONG (SL),
        .SCATTER_SHORT(SS),
        .CHASE_TICKS  (CH),
        .FRIGHT_TICKS (FR),
        .FLASH_TICKS  (FL),
        .CNT_W        (11)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .start       (start),
        .pause       (pause),
        .power_pellet(power_pellet),
        .mode        (mode),
        .reverse     (reverse),
        .flash       (flash),
        .phase       (phase),
        .running     (running)
    );

    typedef struct packed {
        logic [1:0] mode;
        logic       reverse;
        logic       flash;
        logic [2:0] phase;
        logic       running;
    } obs_t;

    obs_t expq[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_rev = 0;
    int   mon_cyc = 0;
    int   e = 0;

    // Reference model: remaining-tick bookkeeping of the schedule
    bit m_run, m_fr, m_prev, m_rev;
    int m_phase, m_left, m_fleft;

    function automatic int dur(int p);
        if (p == 0 || p == 2) return SL;
        if (p == 4 || p == 6) return SS;
        return CH;
    endfunction

    task automatic model_step(bit r, bit t, bit s, bit p, bit pp);
        obs_t o;
        bit act, pel_edge;
        m_rev = 1'b0;
        if (r) begin
            m_run = 0; m_fr = 0; m_prev = 0;
            m_phase = 0; m_left = dur(0); m_fleft = 0;
        end else begin
            act      = t && !p && m_run;
            pel_edge = pp && !m_prev;
            if (!m_run) begin
                if (s) m_run = 1;
            end else if (!m_fr) begin
                if (act && m_phase < 7) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase++;
                        m_left = dur(m_phase);
                        m_rev = 1;
                    end
                end
                if (pel_edge) begin
                    m_fr = 1; m_fleft = FR; m_rev = 1;
                end
            end else begin
                if (pel_edge) m_fleft = FR;
                else if (act) begin
                    m_fleft--;
                    if (m_fleft == 0) m_fr = 0;
                end
            end
            m_prev = pp;
        end
        o.mode    = !m_run ? 2'b00 : (m_fr ? 2'b11 : ((m_phase % 2 == 1) ? 2'b01 : 2'b00));
        o.reverse = m_rev;
        o.flash   = m_fr && (m_fleft <= FL);
        o.phase   = 3'(m_phase);
        o.running = m_run;
        expq.push_back(o);
    endtask

    task automatic drive(bit r, bit t, bit s, bit p, bit pp);
        @(negedge clk);
        rst = r; tick = t; start = s; pause = p; power_pellet = pp;
        model_step(r, t, s, p, pp);
        @(posedge clk);
        e++;
    endtask

    task automatic run(int n, bit t, bit s, bit p, bit pp);
        for (int i = 0; i < n; i++) drive(1'b0, t, s, p, pp);
    endtask

    // Directed checks sample #1 after the edge that drive() just waited for.
    task automatic check(string name, int got, int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, e, got, want);
        end
    endtask

    task automatic reset_and_start();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        e = 0;
    endtask

    always @(posedge clk) begin
        obs_t ex, ac;
        #1;
        if (expq.size() > 0) begin
            ex = expq.pop_front();
            ac = {mode, reverse, flash, phase, running};
            mon_cyc++;
            n_checks++;
            if (ac !== ex) begin
                n_fail++;
                $display("FAIL scoreboard cycle %0d: got mode=%b rev=%b flash=%b phase=%0d run=%b, expected mode=%b rev=%b flash=%b phase=%0d run=%b",
                         mon_cyc, ac.mode, ac.reverse, ac.flash, ac.phase, ac.running,
                         ex.mode, ex.reverse, ex.flash, ex.phase, ex.running);
            end
            if (ac.reverse === 1'b1) n_rev++;
        end
    end

    initial begin
        bit r_tick, r_start, r_pause, r_pel, r_rst;

        // Reset state
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("reset_running", int'(running), 0);
        check("reset_mode", int'(mode), 0);

        // Scenarios 1/2: free-running schedule
        reset_and_start();
        #1;
        check("start_running", int'(running), 1);
        n_rev = 0;
        run(419, 1, 1, 0, 0);
        #1;
        check("s1_mode_before", int'(mode), 0);
        run(1, 1, 1, 0, 0);
        #1;
        check("s1_mode_420", int'(mode), 1);
        check("s1_phase_420", int'(phase), 1);
        check("s1_rev_420", int'(reverse), 1);
        run(1, 1, 0, 0, 0);
        #1;
        check("s1_rev_421", int'(reverse), 0);
        run(5040 - 421, 1, 0, 0, 0);
        #1;
        check("s2_phase_5040", int'(phase), 7);
        run(1500, 1, 0, 0, 0);
        #2;
        check("s2_phase_hold", int'(phase), 7);
        check("s2_mode_hold", int'(mode), 1);
        check("s2_reverse_count", n_rev, 7);

        // Scenario 3: pellet in phase 0
        reset_and_start();
        run(100, 1, 1, 0, 0);
        run(1, 1, 1, 0, 1);
        #1;
        check("s3_mode_fright", int'(mode), 3);
        check("s3_rev_entry", int'(reverse), 1);
        run(239, 1, 1, 0, 0);
        #1;
        check("s3_flash_340", int'(flash), 0);
        run(1, 1, 1, 0, 0);
        #1;
        check("s3_flash_341", int'(flash), 1);
        run(120, 1, 1, 0, 0);
        #1;
        check("s3_mode_461", int'(mode), 0);
        check("s3_flash_461", int'(flash), 0);
        check("s3_rev_461", int'(reverse), 0);
        run(318, 1, 1, 0, 0);
        #1;
        check("s3_phase_779", int'(phase), 0);
        run(1, 1, 1, 0, 0);
        #1;
        check("s3_phase_780", int'(phase), 1);

        // Scenario 4: re-trigger inside fright
        reset_and_start();
        run(100, 1, 1, 0, 0);
        run(1, 1, 1, 0, 1);
        run(198, 1, 1, 0, 0);
        run(1, 1, 1, 0, 1);
        #1;
        check("s4_rev_retrigger", int'(reverse), 0);
        run(359, 1, 1, 0, 0);
        #1;
        check("s4_mode_659", int'(mode), 3);
        run(1, 1, 1, 0, 0);
        #1;
        check("s4_mode_660", int'(mode), 0);

        // Scenario 5: pause delays phase 0, then pellet during pause
        reset_and_start();
        run(100, 1, 1, 0, 0);
        run(50, 1, 1, 1, 0);
        run(319, 1, 1, 0, 0);
        #1;
        check("s5_phase_469", int'(phase), 0);
        run(1, 1, 1, 0, 0);
        #1;
        check("s5_phase_470", int'(phase), 1);
        run(10, 1, 1, 1, 0);
        run(1, 1, 1, 1, 1);
        #1;
        check("s5_mode_paused_pellet", int'(mode), 3);
        run(400, 1, 1, 1, 1);
        #1;
        check("s5_fright_held", int'(mode), 3);
        run(360, 1, 1, 0, 0);
        #1;
        check("s5_fright_over", int'(mode), 1);

        // Scenario 6: pellet coincident with phase-0 expiry, then reset in fright
        reset_and_start();
        run(419, 1, 1, 0, 0);
        n_rev = 0;
        run(1, 1, 1, 0, 1);
        #1;
        check("s6_phase", int'(phase), 1);
        check("s6_mode", int'(mode), 3);
        run(360, 1, 1, 0, 0);
        #2;
        check("s6_rev_once", n_rev, 1);
        check("s6_mode_after", int'(mode), 1);
        run(50, 1, 1, 0, 1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        #1;
        check("s6_rst_mode", int'(mode), 0);
        check("s6_rst_running", int'(running), 0);
        check("s6_rst_phase", int'(phase), 0);

        // Random traffic
        r_tick = 1; r_start = 1; r_pause = 0; r_pel = 0;
        for (int i = 0; i < 20000; i++) begin
            r_rst = ($urandom_range(0, 2999) == 0);
            r_tick = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 99) == 0) r_pause = ~r_pause;
            if ($urandom_range(0, 149) == 0) r_pel = ~r_pel;
            r_start = ($urandom_range(0, 3) != 0);
            drive(r_rst, r_tick, r_start, r_pause, r_pel);
        end

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clk);
        #2;
        check("scoreboard_drained", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
